// File: rtl/vec_exec_pkg.sv
// vec_exec_pkg: shared definitions for the vector execution unit.
//   - op_e       : operation encodings driven on the Op port
//   - state_e    : control FSM states
//   - range_fix  : maps an out-of-range result back to WIDTH bits
// Build option: define VEC_EXEC_SAT_EN to clamp out-of-range values to the
// signed WIDTH limits; otherwise values wrap modulo 2^WIDTH.
package vec_exec_pkg;

  // Widest element supported by range_fix; WIDTH must not exceed this.
  localparam int unsigned MAX_W = 32;

  typedef enum logic [1:0] {
    OP_VADD = 2'b00,
    OP_VDOT = 2'b01,
    OP_SMUL = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // value must be sign-extended to 2*MAX_W bits by the caller; ovf says it
  // lies outside the signed width-bit range. Caller keeps the low width bits.
  function automatic logic [MAX_W-1:0] range_fix(input logic [2*MAX_W-1:0] value,
                                                 input logic               ovf,
                                                 input int unsigned        width);
`ifdef VEC_EXEC_SAT_EN
    logic [MAX_W-1:0] max_pos;
    max_pos = (MAX_W'(1) << (width - 1)) - MAX_W'(1);
    if (ovf) begin
      return value[2*MAX_W-1] ? ~max_pos : max_pos;
    end
    return value[MAX_W-1:0];
`else
    return value[MAX_W-1:0];
`endif
  endfunction

endpackage

// File: rtl/vec_exec_unit_lane_alu.sv
// vec_lane_alu: combinational single-lane signed add or multiply.
//   a, b : WIDTH-bit signed operands
//   mul  : 1 = a*b, 0 = a+b
//   res  : result after range_fix (saturate or wrap, see VEC_EXEC_SAT_EN)
//   ovf  : exact result does not fit in signed WIDTH bits
module vec_lane_alu
  import vec_exec_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mul,
  output logic [WIDTH-1:0] res,
  output logic             ovf
);

  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;
  logic signed [2*WIDTH-1:0] full;

  always_comb begin
    a_ext = (2*WIDTH)'(signed'(a));
    b_ext = (2*WIDTH)'(signed'(b));
    // 2*WIDTH bits hold any sum or product of two WIDTH-bit operands exactly.
    full  = mul ? (a_ext * b_ext) : (a_ext + b_ext);
    // In range iff the upper WIDTH+1 bits are all copies of the sign bit.
    ovf   = (full[2*WIDTH-1:WIDTH-1] != '0) && (full[2*WIDTH-1:WIDTH-1] != '1);
    res   = WIDTH'(range_fix((2*MAX_W)'(full), ovf, WIDTH));
  end

endmodule

// File: rtl/vec_exec_unit.sv
// vec_exec_unit: multi-cycle vector execution unit (vadd, vdot, smul, nop).
// Processes LPC lanes per clock over N = LANES/LPC RUN cycles.
//   Clk1   : clock, all logic on posedge
//   Reset  : synchronous, active-high
//   Start  : request, accepted only when idle
//   Op     : 00 vadd, 01 vdot, 10 smul, 11 nop
//   VecA   : operand A, lane i at [i*WIDTH +: WIDTH]
//   VecB   : operand B (vadd, vdot)
//   Scalar : scalar operand (smul)
//   Busy   : high while an operation is in flight, through the Done cycle
//   Done   : one-cycle completion pulse
//   Result : vector result (vadd, smul, nop)
//   DotOut : dot-product result (vdot)
//   V      : sticky overflow for the current operation
// Build option: VEC_EXEC_SAT_EN selects saturation instead of wrap.
module vec_exec_unit
  import vec_exec_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 16,
  parameter int unsigned LPC   = 4
) (
  input  logic                   Clk1,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic [1:0]             Op,
  input  logic [LANES*WIDTH-1:0] VecA,
  input  logic [LANES*WIDTH-1:0] VecB,
  input  logic [WIDTH-1:0]       Scalar,
  output logic                   Busy,
  output logic                   Done,
  output logic [LANES*WIDTH-1:0] Result,
  output logic [WIDTH-1:0]       DotOut,
  output logic                   V
);

  localparam int unsigned N  = LANES / LPC;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [LANES*WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [WIDTH-1:0]       scalar_q, scalar_d, acc_q, acc_d, dot_q, dot_d;
  logic                   busy_q, busy_d, done_q, done_d, v_q, v_d;

  logic [LPC*WIDTH-1:0]   lane_a, lane_b, lane_res;
  logic [LPC-1:0]         lane_ovf;
  logic                   lane_mul;

  logic [WIDTH-1:0]          chain_acc;
  logic                      chain_v;
  logic signed [2*WIDTH-1:0] step;
  logic                      step_ovf;

  // Operand slices for the chunk selected by the lane counter.
  always_comb begin
    lane_a   = '0;
    lane_b   = '0;
    lane_mul = (op_q != OP_VADD);
    for (int unsigned j = 0; j < LPC; j++) begin
      lane_a[j*WIDTH +: WIDTH] = a_q[(32'(cnt_q) * LPC + j) * WIDTH +: WIDTH];
      lane_b[j*WIDTH +: WIDTH] = (op_q == OP_SMUL) ? scalar_q
                                 : b_q[(32'(cnt_q) * LPC + j) * WIDTH +: WIDTH];
    end
  end

  for (genvar g = 0; g < LPC; g++) begin : g_lane
    vec_lane_alu #(.WIDTH(WIDTH)) u_alu (
      .a   (lane_a[g*WIDTH +: WIDTH]),
      .b   (lane_b[g*WIDTH +: WIDTH]),
      .mul (lane_mul),
      .res (lane_res[g*WIDTH +: WIDTH]),
      .ovf (lane_ovf[g])
    );
  end

  // vdot: fold this chunk's range-fixed products into the accumulator in
  // ascending lane order, range-fixing after every addition.
  always_comb begin
    chain_acc = acc_q;
    chain_v   = 1'b0;
    step      = '0;
    step_ovf  = 1'b0;
    for (int unsigned j = 0; j < LPC; j++) begin
      step      = (2*WIDTH)'(signed'(chain_acc)) + (2*WIDTH)'(signed'(lane_res[j*WIDTH +: WIDTH]));
      step_ovf  = (step[2*WIDTH-1:WIDTH-1] != '0) && (step[2*WIDTH-1:WIDTH-1] != '1);
      chain_v   = chain_v | lane_ovf[j] | step_ovf;
      chain_acc = WIDTH'(range_fix((2*MAX_W)'(step), step_ovf, WIDTH));
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    scalar_d = scalar_q;
    acc_d    = acc_q;
    dot_d    = dot_q;
    result_d = result_q;
    v_d      = v_q;
    // Busy/Done are registered from the state, so they trail it by a cycle:
    // Busy rises one edge after acceptance and Done pulses the cycle after
    // the DONE state. Acceptance also waits for Busy to fall so a Start
    // during the Done pulse is ignored.
    busy_d   = (state_q != ST_IDLE);
    done_d   = (state_q == ST_DONE);

    unique case (state_q)
      ST_IDLE: begin
        if (Start && !busy_q) begin
          a_d      = VecA;
          b_d      = VecB;
          scalar_d = Scalar;
          op_d     = op_e'(Op);
          v_d      = 1'b0;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int unsigned j = 0; j < LPC; j++) begin
          if (op_q == OP_NOP) begin
            result_d[(32'(cnt_q) * LPC + j) * WIDTH +: WIDTH] = lane_a[j*WIDTH +: WIDTH];
          end else if (op_q != OP_VDOT) begin
            result_d[(32'(cnt_q) * LPC + j) * WIDTH +: WIDTH] = lane_res[j*WIDTH +: WIDTH];
          end
        end
        unique case (op_q)
          OP_VADD, OP_SMUL: v_d = v_q | (|lane_ovf);
          OP_VDOT: begin
            acc_d = chain_acc;
            v_d   = v_q | chain_v;
          end
          default: ;
        endcase
        if (cnt_q == CW'(N - 1)) begin
          state_d = ST_DONE;
          if (op_q == OP_VDOT) begin
            dot_d = chain_acc;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NOP;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      scalar_q <= '0;
      acc_q    <= '0;
      dot_q    <= '0;
      result_q <= '0;
      v_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      scalar_q <= scalar_d;
      acc_q    <= acc_d;
      dot_q    <= dot_d;
      result_q <= result_d;
      v_q      <= v_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;
  assign DotOut = dot_q;
  assign V      = v_q;

endmodule
